cache_fill_controller: RTL and testbench
========================================

Name: cache_fill_controller

Overview:
- Sequencing FSM between the CPU request port, a direct-mapped cache array and a multi-cycle main memory.
- Read hit: served from the cache. Read miss: refills the whole block word-by-word from memory, then serves the read from the cache.
- Writes: write-through. Memory is always written; the cache is updated only on a hit (no-write-allocate).
- Keeps saturating hit and miss statistics counters.

Parameters:
- BLOCK_WORDS, 4: words per cache block. Must be a power of two, ≥2.
- WORD_W, 2: fillIdx width, equal to log2(BLOCK_WORDS).
- CNT_W, 16: width of the hit and miss statistic counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- cpuReq  in  1  CPU request. Held high until cpuReady is seen.
- cpuWr  in  1  1 = write, 0 = read. Stable while cpuReq is high.
- hit  in  1  tag-compare result for the current CPU address (combinational, from the cache).
- memReady  in  1  memory has completed the current word read or write.
- statClr  in  1  synchronous clear of hitCnt and missCnt.
- cRead  out  1  cache array read enable.
- cWrite  out  1  cache array write enable (fill word or write-through update).
- rRead  out  1  memory read request.
- rWrite  out  1  memory write request.
- selOut  out  1  CPU data mux: 1 = cache data, 0 = memory data.
- cpuReady  out  1  one-cycle completion pulse to the CPU.
- busy  out  1  controller is not in IDLE.
- fillIdx  out  WORD_W  word offset of the current refill beat.
- hitCnt  out  CNT_W  read hits plus write hits, saturating.
- missCnt  out  CNT_W  read misses plus write misses, saturating.

Behaviour:
- States: IDLE, RD_HIT, FILL, WR_MEM, DONE.
- State, fillIdx, counters and hitLatch are registers. All other outputs are decoded from state and inputs.

Reset (rst=0, any time, including mid-FILL or mid-WR_MEM):
- state=IDLE, fillIdx=0, hitCnt=0, missCnt=0, hitLatch=0.
- All control outputs 0, including selOut=0.
- An in-flight memory transaction is abandoned. Memory must tolerate rRead/rWrite dropping.

IDLE:
- All control outputs 0.
- memReady is ignored.
- On a clock edge with cpuReq=1, cpuWr=0 and hit=1: go to RD_HIT, hitCnt++.
- On a clock edge with cpuReq=1, cpuWr=0 and hit=0: go to FILL, missCnt++, fillIdx=0.
- On a clock edge with cpuReq=1 and cpuWr=1: go to WR_MEM, hitLatch=hit, and hitCnt++ if hit else missCnt++.

RD_HIT:
- Outputs: cRead=1, selOut=1, cpuReady=1. Lasts exactly one cycle, then IDLE.
- Read-hit latency: cpuReady is high in the cycle after the sampling edge.

FILL:
- rRead=1 throughout.
- Each cycle with memReady=1: cWrite=1 (same cycle, writes the memory word at fillIdx), and fillIdx increments at the edge.
- On the edge where memReady=1 and fillIdx=BLOCK_WORDS-1: fillIdx wraps to 0 and state goes to RD_HIT, which delivers the data from the now-valid block.
- memReady=0 inserts wait cycles. There is no timeout.

WR_MEM:
- rWrite=1 until memReady=1.
- In the memReady cycle, cWrite=hitLatch (write-through update on hit only).
- Next state: DONE.

DONE:
- cpuReady=1, selOut=0, all enables 0. Lasts one cycle, then IDLE.

busy:
- 1 in every state except IDLE.

Counters:
- Saturate at all-ones and never wrap.
- statClr=1 clears both counters at the edge and takes priority over a same-edge increment.

Simultaneity:
- The cpuReq of a new request is not sampled in RD_HIT or DONE. At least one IDLE cycle separates transactions.
- hit is ignored outside IDLE.
- hitLatch is used only in WR_MEM.

Test Plan:
- Read hit: rst released, cpuReq=1, cpuWr=0, hit=1 at edge 1 -> cycle after edge 1 has cRead=1, selOut=1, cpuReady=1; hitCnt=1, missCnt=0; IDLE after edge 2.
- Read miss, BLOCK_WORDS=4, memReady=1 every other cycle -> rRead high for 8 cycles; cWrite pulses 4 times with fillIdx 0,1,2,3; then one RD_HIT cycle with cpuReady=1 and selOut=1; missCnt=1; fillIdx back to 0.
- Write hit with memReady after 3 cycles -> rWrite high for 3 cycles, cWrite=1 only in the 3rd; DONE cycle has cpuReady=1 and selOut=0. Write miss, same timing -> cWrite stays 0; missCnt increments.
- Reset mid-fill: rst=0 after fillIdx=2 -> all outputs and fillIdx 0 immediately (asynchronous); a new read miss after release starts again at fillIdx=0.
- Saturation/clear with CNT_W=2: 5 read hits -> hitCnt=3. statClr=1 on the same edge as a 6th hit -> hitCnt=0.
- memReady pulses while in IDLE -> no cWrite, no state change, busy=0.

Source files
------------

// File: rtl/cache_fill_controller.sv
// cache_fill_controller
//   Sequencing FSM between a CPU request port, a direct-mapped cache array
//   and a multi-cycle main memory. Read hits are served from the cache. Read
//   misses refill the whole block word by word, then serve from the cache.
//   Writes go through to memory and update the cache only on a hit
//   (no-write-allocate). Saturating hit/miss statistics counters are kept.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   cpuReq   in   CPU request, held until cpuReady
//   cpuWr    in   1 = write, 0 = read
//   hit      in   tag-compare result for the current CPU address
//   memReady in   memory finished the current word read/write
//   statClr  in   synchronous clear of hitCnt/missCnt
//   cRead    out  cache array read enable
//   cWrite   out  cache array write enable (fill word or write-through update)
//   rRead    out  memory read request
//   rWrite   out  memory write request
//   selOut   out  CPU data mux: 1 = cache, 0 = memory
//   cpuReady out  one-cycle completion pulse
//   busy     out  controller not idle
//   fillIdx  out  word offset of the current refill beat
//   hitCnt   out  saturating hit counter
//   missCnt  out  saturating miss counter
module cache_fill_controller #(
    parameter int BLOCK_WORDS = 4,
    parameter int WORD_W      = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpuReq,
    input  logic              cpuWr,
    input  logic              hit,
    input  logic              memReady,
    input  logic              statClr,
    output logic              cRead,
    output logic              cWrite,
    output logic              rRead,
    output logic              rWrite,
    output logic              selOut,
    output logic              cpuReady,
    output logic              busy,
    output logic [WORD_W-1:0] fillIdx,
    output logic [CNT_W-1:0]  hitCnt,
    output logic [CNT_W-1:0]  missCnt
);

    typedef enum logic [2:0] {
        IDLE,
        RD_HIT,
        FILL,
        WR_MEM,
        DONE
    } state_t;

    state_t state;
    logic   hitLatch;
    logic   accept;
    logic   last_beat;

    // Every accepted request, read or write, counts as exactly one hit or miss.
    assign accept    = (state == IDLE) && cpuReq;
    assign last_beat = (fillIdx == WORD_W'(BLOCK_WORDS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            fillIdx  <= '0;
            hitCnt   <= '0;
            missCnt  <= '0;
            hitLatch <= 1'b0;
        end else begin
            // Clear has priority over a same-edge increment.
            if (statClr) begin
                hitCnt  <= '0;
                missCnt <= '0;
            end else if (accept) begin
                if (hit) begin
                    if (hitCnt != '1) hitCnt <= hitCnt + 1'b1;
                end else begin
                    if (missCnt != '1) missCnt <= missCnt + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (cpuReq) begin
                        if (cpuWr) begin
                            state    <= WR_MEM;
                            hitLatch <= hit;
                        end else if (hit) begin
                            state <= RD_HIT;
                        end else begin
                            state   <= FILL;
                            fillIdx <= '0;
                        end
                    end
                end
                RD_HIT: state <= IDLE;
                FILL: begin
                    if (memReady) begin
                        // Power-of-two block: increment wraps to 0 on the last beat.
                        fillIdx <= fillIdx + 1'b1;
                        if (last_beat) state <= RD_HIT;
                    end
                end
                WR_MEM: begin
                    if (memReady) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        cRead    = 1'b0;
        cWrite   = 1'b0;
        rRead    = 1'b0;
        rWrite   = 1'b0;
        selOut   = 1'b0;
        cpuReady = 1'b0;
        busy     = (state != IDLE);
        case (state)
            RD_HIT: begin
                cRead    = 1'b1;
                selOut   = 1'b1;
                cpuReady = 1'b1;
            end
            FILL: begin
                rRead  = 1'b1;
                cWrite = memReady;
            end
            WR_MEM: begin
                rWrite = 1'b1;
                cWrite = memReady && hitLatch;
            end
            DONE:    cpuReady = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_controller.sv
// Testbench for cache_fill_controller (BLOCK_WORDS=4, CNT_W=2).
// Each vector gives one cycle of inputs and the outputs expected in that
// cycle, before the next rising edge.
module tb_cache_fill_controller;

    logic       clk = 1'b0;
    logic       rst, cpuReq, cpuWr, hit, memReady, statClr;
    logic       cRead, cWrite, rRead, rWrite, selOut, cpuReady, busy;
    logic [1:0] fillIdx, hitCnt, missCnt;

    always #5 clk = ~clk;

    cache_fill_controller #(
        .BLOCK_WORDS(4),
        .WORD_W     (2),
        .CNT_W      (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cpuReq  (cpuReq),
        .cpuWr   (cpuWr),
        .hit     (hit),
        .memReady(memReady),
        .statClr (statClr),
        .cRead   (cRead),
        .cWrite  (cWrite),
        .rRead   (rRead),
        .rWrite  (rWrite),
        .selOut  (selOut),
        .cpuReady(cpuReady),
        .busy    (busy),
        .fillIdx (fillIdx),
        .hitCnt  (hitCnt),
        .missCnt (missCnt)
    );

    // stim = {rst, cpuReq, cpuWr, hit, memReady, statClr}
    // ctl  = {cRead, cWrite, rRead, rWrite, selOut, cpuReady, busy}
    typedef struct {
        logic [5:0] stim;
        logic [6:0] ctl;
        logic [1:0] fi;
        logic [1:0] hc;
        logic [1:0] mc;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   checks = 0;
    int   passed = 0;

    function automatic vec_t v(input logic [5:0] s, input logic [6:0] o,
                               input int f, input int h, input int m);
        vec_t r;
        r.stim = s;
        r.ctl  = o;
        r.fi   = 2'(f);
        r.hc   = 2'(h);
        r.mc   = 2'(m);
        return r;
    endfunction

    task automatic drive(input vec_t x);
        {rst, cpuReq, cpuWr, hit, memReady, statClr} = x.stim;
        sb.push_back(x);
    endtask

    task automatic check(input string name);
        vec_t       e;
        logic [6:0] act_ctl;
        #1;
        e       = sb.pop_front();
        act_ctl = {cRead, cWrite, rRead, rWrite, selOut, cpuReady, busy};
        checks++;
        if (act_ctl === e.ctl && fillIdx === e.fi && hitCnt === e.hc && missCnt === e.mc)
            passed++;
        else
            $display("FAIL %s: got ctl=%b fi=%0d hc=%0d mc=%0d, want ctl=%b fi=%0d hc=%0d mc=%0d",
                     name, act_ctl, fillIdx, hitCnt, missCnt, e.ctl, e.fi, e.hc, e.mc);
    endtask

    task automatic apply(input vec_t x, input string name);
        @(negedge clk);
        drive(x);
        check(name);
    endtask

    initial begin
        rst = 1'b0; cpuReq = 1'b0; cpuWr = 1'b0; hit = 1'b0; memReady = 1'b0; statClr = 1'b0;

        // reset held, then read hit
        tbl.push_back(v(6'b010100, 7'b0000000, 0, 0, 0));
        tbl.push_back(v(6'b110100, 7'b0000000, 0, 0, 0));
        tbl.push_back(v(6'b110100, 7'b1000111, 0, 1, 0));
        // memReady in IDLE is ignored
        tbl.push_back(v(6'b100010, 7'b0000000, 0, 1, 0));
        tbl.push_back(v(6'b100010, 7'b0000000, 0, 1, 0));
        // read miss, memReady every other cycle
        tbl.push_back(v(6'b110000, 7'b0000000, 0, 1, 0));
        tbl.push_back(v(6'b110000, 7'b0010001, 0, 1, 1));
        tbl.push_back(v(6'b110010, 7'b0110001, 0, 1, 1));
        tbl.push_back(v(6'b110000, 7'b0010001, 1, 1, 1));
        tbl.push_back(v(6'b110010, 7'b0110001, 1, 1, 1));
        tbl.push_back(v(6'b110000, 7'b0010001, 2, 1, 1));
        tbl.push_back(v(6'b110010, 7'b0110001, 2, 1, 1));
        tbl.push_back(v(6'b110000, 7'b0010001, 3, 1, 1));
        tbl.push_back(v(6'b110010, 7'b0110001, 3, 1, 1));
        tbl.push_back(v(6'b110010, 7'b1000111, 0, 1, 1));
        tbl.push_back(v(6'b100000, 7'b0000000, 0, 1, 1));
        // write hit, memReady on third WR_MEM cycle
        tbl.push_back(v(6'b111100, 7'b0000000, 0, 1, 1));
        tbl.push_back(v(6'b111000, 7'b0001001, 0, 2, 1));
        tbl.push_back(v(6'b111000, 7'b0001001, 0, 2, 1));
        tbl.push_back(v(6'b111010, 7'b0101001, 0, 2, 1));
        tbl.push_back(v(6'b111000, 7'b0000011, 0, 2, 1));
        tbl.push_back(v(6'b100000, 7'b0000000, 0, 2, 1));
        // write miss, same timing; hit toggling in WR_MEM is ignored
        tbl.push_back(v(6'b111000, 7'b0000000, 0, 2, 1));
        tbl.push_back(v(6'b111100, 7'b0001001, 0, 2, 2));
        tbl.push_back(v(6'b111100, 7'b0001001, 0, 2, 2));
        tbl.push_back(v(6'b111110, 7'b0001001, 0, 2, 2));
        tbl.push_back(v(6'b111100, 7'b0000011, 0, 2, 2));
        tbl.push_back(v(6'b100000, 7'b0000000, 0, 2, 2));
        // clear, then 5 hits saturate at 3, 6th hit with clear gives 0
        tbl.push_back(v(6'b100001, 7'b0000000, 0, 2, 2));
        tbl.push_back(v(6'b110100, 7'b0000000, 0, 0, 0));
        tbl.push_back(v(6'b110100, 7'b1000111, 0, 1, 0));
        tbl.push_back(v(6'b110100, 7'b0000000, 0, 1, 0));
        tbl.push_back(v(6'b110100, 7'b1000111, 0, 2, 0));
        tbl.push_back(v(6'b110100, 7'b0000000, 0, 2, 0));
        tbl.push_back(v(6'b110100, 7'b1000111, 0, 3, 0));
        tbl.push_back(v(6'b110100, 7'b0000000, 0, 3, 0));
        tbl.push_back(v(6'b110100, 7'b1000111, 0, 3, 0));
        tbl.push_back(v(6'b110100, 7'b0000000, 0, 3, 0));
        tbl.push_back(v(6'b110100, 7'b1000111, 0, 3, 0));
        tbl.push_back(v(6'b110101, 7'b0000000, 0, 3, 0));
        tbl.push_back(v(6'b100000, 7'b1000111, 0, 0, 0));
        tbl.push_back(v(6'b100000, 7'b0000000, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        // asynchronous reset in the middle of a refill
        apply(v(6'b110000, 7'b0000000, 0, 0, 0), "rst_miss_req");
        apply(v(6'b110010, 7'b0110001, 0, 0, 1), "rst_fill0");
        apply(v(6'b110010, 7'b0110001, 1, 0, 1), "rst_fill1");
        apply(v(6'b110010, 7'b0110001, 2, 0, 1), "rst_fill2");
        drive(v(6'b010010, 7'b0000000, 0, 0, 0));
        check("rst_async");
        apply(v(6'b010010, 7'b0000000, 0, 0, 0), "rst_held");
        apply(v(6'b110000, 7'b0000000, 0, 0, 0), "refill_req");
        apply(v(6'b110010, 7'b0110001, 0, 0, 1), "refill_beat0");
        apply(v(6'b110000, 7'b0010001, 1, 0, 1), "refill_wait1");

        if (sb.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: got %0d leftover, want 0", sb.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
